// File: rtl/control_sequencer_pkg.sv
//------------------------------------------------------------------------------
// control_sequencer_pkg
// Opcode class codes, SYS opcode values, field positions and FSM state encoding
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package control_sequencer_pkg;

    typedef enum logic [1:0] {
        CLS_MOV = 2'b00,
        CLS_ALU = 2'b01,
        CLS_MEM = 2'b10,
        CLS_SYS = 2'b11
    } op_class_t;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_HALT   = 2'd3
    } seq_state_t;

    localparam logic [7:0] c_op_nop = 8'hC0;
    localparam logic [7:0] c_op_hlt = 8'hFF;

    localparam int c_cls_msb      = 7;
    localparam int c_cls_lsb      = 6;
    localparam int c_dst_msb      = 5;
    localparam int c_dst_lsb      = 3;
    localparam int c_src_msb      = 2;
    localparam int c_src_lsb      = 0;
    localparam int c_mem_st_bit   = 5;
    localparam int c_mem_rsvd_bit = 4;
    localparam int c_mem_addr_msb = 3;

    function automatic logic reg_out_of_range(input logic [2:0] sel, input int num_regs);
        return (int'({29'd0, sel}) >= num_regs);
    endfunction

endpackage

`default_nettype wire

// File: rtl/control_sequencer_if.sv
//------------------------------------------------------------------------------
// control_sequencer_if
// Instruction-fetch and data-memory handshake bundle of the sequencer
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface control_sequencer_if #(
    parameter int PC_W = 8
);
    logic            instr_req;
    logic [PC_W-1:0] instr_addr;
    logic            instr_valid;
    logic [7:0]      instr_data;
    logic            mem_req;
    logic            mem_write;
    logic [3:0]      mem_addr;
    logic            mem_ack;

    modport master (
        output instr_req, instr_addr, mem_req, mem_write, mem_addr,
        input  instr_valid, instr_data, mem_ack
    );

    modport slave (
        input  instr_req, instr_addr, mem_req, mem_write, mem_addr,
        output instr_valid, instr_data, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/control_sequencer_decode.sv
//------------------------------------------------------------------------------
// instr_field_decode
// Combinational opcode split into class, register/ALU/memory fields and legality
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_field_decode
    import control_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 4
) (
    input  wire logic [7:0] i_opcode,
    output op_class_t       o_op_class,
    output logic [2:0]      o_dst,
    output logic [2:0]      o_src,
    output logic [2:0]      o_alu,
    output logic [3:0]      o_mem_addr,
    output logic            o_mem_store,
    output logic            o_is_hlt,
    output logic            o_illegal
);

    always_comb begin
        o_op_class  = op_class_t'(i_opcode[c_cls_msb:c_cls_lsb]);
        o_dst       = i_opcode[c_dst_msb:c_dst_lsb];
        o_src       = i_opcode[c_src_msb:c_src_lsb];
        o_alu       = i_opcode[c_dst_msb:c_dst_lsb];
        o_mem_addr  = i_opcode[c_mem_addr_msb:0];
        o_mem_store = i_opcode[c_mem_st_bit];
        o_is_hlt    = (i_opcode == c_op_hlt);
        o_illegal   = 1'b0;
        case (o_op_class)
            CLS_MOV: o_illegal = reg_out_of_range(o_dst, NUM_REGS)
                               | reg_out_of_range(o_src, NUM_REGS)
                               | (o_dst == o_src);
            CLS_ALU: o_illegal = reg_out_of_range(o_src, NUM_REGS);
            CLS_MEM: o_illegal = i_opcode[c_mem_rsvd_bit];
            CLS_SYS: o_illegal = !((i_opcode == c_op_nop) || (i_opcode == c_op_hlt));
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer
// Fetch/decode/execute controller driving register-bank, ALU and memory strobes.
// Build option: CTRL_ILLEGAL_TRAP_EN -- illegal opcode halts instead of acting as NOP
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int NUM_REGS = 4,
    parameter int PC_W     = 8,
    parameter int SEL_W    = 3
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic                run,
    control_sequencer_if.master      bus,
    output logic [2:0]               alu_sel,
    output logic [SEL_W-1:0]         src_sel,
    output logic [NUM_REGS-1:0]      dst_we,
    output logic                     halted,
    output logic                     illegal
);

    localparam logic [NUM_REGS-1:0] c_reg0_we = NUM_REGS'(1);

    seq_state_t            r_state;
    logic [7:0]            r_opcode;
    logic [PC_W-1:0]       r_pc;
    logic                  r_instr_req;
    logic                  r_mem_req;
    logic                  r_mem_write;
    logic [3:0]            r_mem_addr;
    logic                  r_ld_pending;
    logic [NUM_REGS-1:0]   r_dst_we;
    logic [SEL_W-1:0]      r_src_sel;
    logic [2:0]            r_alu_sel;
    logic                  r_halted;
    logic                  r_illegal;

    op_class_t             w_op_class;
    logic [2:0]            w_dst;
    logic [2:0]            w_src;
    logic [2:0]            w_alu;
    logic [3:0]            w_mem_addr;
    logic                  w_mem_store;
    logic                  w_is_hlt;
    logic                  w_illegal;
    logic                  w_accept;
    logic [NUM_REGS-1:0]   w_dst_onehot;

    instr_field_decode #(
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .i_opcode    (r_opcode),
        .o_op_class  (w_op_class),
        .o_dst       (w_dst),
        .o_src       (w_src),
        .o_alu       (w_alu),
        .o_mem_addr  (w_mem_addr),
        .o_mem_store (w_mem_store),
        .o_is_hlt    (w_is_hlt),
        .o_illegal   (w_illegal)
    );

    // The request is only ever raised in FETCH, so no state qualifier is needed.
    assign w_accept     = r_instr_req & bus.instr_valid;
    assign w_dst_onehot = c_reg0_we << w_dst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_FETCH;
            r_opcode     <= '0;
            r_pc         <= '0;
            r_instr_req  <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_addr   <= '0;
            r_ld_pending <= 1'b0;
            r_dst_we     <= '0;
            r_src_sel    <= '0;
            r_alu_sel    <= '0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else begin
            r_dst_we <= '0;
            case (r_state)
                ST_FETCH: begin
                    if (w_accept) begin
                        r_opcode    <= bus.instr_data;
                        r_pc        <= r_pc + PC_W'(1);
                        r_instr_req <= 1'b0;
                        r_state     <= ST_DECODE;
                    end else begin
                        r_instr_req <= run;
                    end
                end
                ST_DECODE: begin
                    if (w_illegal) begin
                        r_illegal <= 1'b1;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        r_halted  <= 1'b1;
                        r_state   <= ST_HALT;
`else
                        r_instr_req <= run;
                        r_state     <= ST_FETCH;
`endif
                    end else begin
                        case (w_op_class)
                            CLS_MOV: begin
                                r_src_sel <= SEL_W'(w_src);
                                r_dst_we  <= w_dst_onehot;
                                r_state   <= ST_EXEC;
                            end
                            CLS_ALU: begin
                                r_alu_sel <= w_alu;
                                r_src_sel <= SEL_W'(w_src);
                                r_dst_we  <= c_reg0_we;
                                r_state   <= ST_EXEC;
                            end
                            CLS_MEM: begin
                                r_mem_req    <= 1'b1;
                                r_mem_write  <= w_mem_store;
                                r_mem_addr   <= w_mem_addr;
                                r_ld_pending <= !w_mem_store;
                                if (w_mem_store) begin
                                    r_src_sel <= '0;
                                end
                                r_state <= ST_EXEC;
                            end
                            default: begin
                                if (w_is_hlt) begin
                                    r_halted <= 1'b1;
                                    r_state  <= ST_HALT;
                                end else begin
                                    r_instr_req <= run;
                                    r_state     <= ST_FETCH;
                                end
                            end
                        endcase
                    end
                end
                ST_EXEC: begin
                    if (!r_mem_req || bus.mem_ack) begin
                        r_mem_req    <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_mem_addr   <= '0;
                        r_ld_pending <= 1'b0;
                        r_instr_req  <= run;
                        r_state      <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_FETCH;
                end
            endcase
        end
    end

    // A load writes r0 in the very cycle the memory acknowledges it.
    assign dst_we = r_dst_we
                  | ((r_ld_pending & bus.mem_ack) ? c_reg0_we : '0);

    assign bus.instr_req  = r_instr_req;
    assign bus.instr_addr = r_pc;
    assign bus.mem_req    = r_mem_req;
    assign bus.mem_write  = r_mem_write;
    assign bus.mem_addr   = r_mem_addr;
    assign alu_sel        = r_alu_sel;
    assign src_sel        = r_src_sel;
    assign halted         = r_halted;
    assign illegal        = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_control_sequencer.sv
//------------------------------------------------------------------------------
// tb_control_sequencer
// Directed-vector bench for control_sequencer (NUM_REGS = 4, PC_W = 8)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_control_sequencer;

    logic       clk;
    logic       rst;
    logic       run;
    logic [2:0] alu_sel;
    logic [2:0] src_sel;
    logic [3:0] dst_we;
    logic       halted;
    logic       illegal;

    int n_cmp;
    int n_err;

    control_sequencer_if #(.PC_W(8)) bus_if ();

    control_sequencer #(
        .NUM_REGS (4),
        .PC_W     (8),
        .SEL_W    (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .bus     (bus_if),
        .alu_sel (alu_sel),
        .src_sel (src_sel),
        .dst_we  (dst_we),
        .halted  (halted),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst                = 1'b1;
        bus_if.instr_valid = 1'b0;
        bus_if.mem_ack     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for a fetch request, presents the opcode and returns in the cycle after acceptance.
    task automatic fetch(input logic [7:0] op);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_if.instr_req === 1'b1) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        if (!seen) check_eq("instr_req_timeout", 32'd0, 32'd1);
        bus_if.instr_valid = 1'b1;
        bus_if.instr_data  = op;
        tick();
        bus_if.instr_valid = 1'b0;
        bus_if.instr_data  = 8'h00;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp              = 0;
        n_err              = 0;
        run                = 1'b0;
        bus_if.instr_valid = 1'b0;
        bus_if.instr_data  = 8'h00;
        bus_if.mem_ack     = 1'b0;

        // Reset state
        apply_reset();
        check_eq("rst_instr_req", 32'(bus_if.instr_req), 32'd0);
        check_eq("rst_instr_addr", 32'(bus_if.instr_addr), 32'd0);
        check_eq("rst_mem_req", 32'(bus_if.mem_req), 32'd0);
        check_eq("rst_dst_we", 32'(dst_we), 32'd0);
        check_eq("rst_halted", 32'(halted), 32'd0);
        check_eq("rst_illegal", 32'(illegal), 32'd0);
        run = 1'b1;

        // MOV r0 <- r1: strobe exactly in cycle N+2, request again in N+3
        fetch(8'h01);
        check_eq("mov_decode_we", 32'(dst_we), 32'd0);
        tick();
        check_eq("mov_dst_we", 32'(dst_we), 32'h1);
        check_eq("mov_src_sel", 32'(src_sel), 32'd1);
        check_eq("mov_req_low", 32'(bus_if.instr_req), 32'd0);
        tick();
        check_eq("mov_we_drop", 32'(dst_we), 32'd0);
        check_eq("mov_req_again", 32'(bus_if.instr_req), 32'd1);
        check_eq("mov_pc", 32'(bus_if.instr_addr), 32'd1);

        // ALU op 1, src r2
        fetch(8'h4A);
        tick();
        check_eq("alu_sel", 32'(alu_sel), 32'd1);
        check_eq("alu_src_sel", 32'(src_sel), 32'd2);
        check_eq("alu_dst_we", 32'(dst_we), 32'h1);
        tick();
        check_eq("alu_pc", 32'(bus_if.instr_addr), 32'd2);

        // MOV r3 <- r2
        fetch(8'h1A);
        tick();
        check_eq("mov3_dst_we", 32'(dst_we), 32'h8);
        check_eq("mov3_src_sel", 32'(src_sel), 32'd2);
        check_eq("mov3_alu_hold", 32'(alu_sel), 32'd1);
        tick();

        // Stray mem_ack with no request outstanding
        bus_if.mem_ack = 1'b1;
        #1;
        check_eq("stray_ack_we", 32'(dst_we), 32'd0);
        tick();
        bus_if.mem_ack = 1'b0;
        check_eq("stray_ack_mem_req", 32'(bus_if.mem_req), 32'd0);

        // ST addr 5 with ack arriving in the third request cycle
        fetch(8'hA5);
        tick();
        for (int k = 0; k < 3; k++) begin
            check_eq("st_mem_req", 32'(bus_if.mem_req), 32'd1);
            check_eq("st_mem_write", 32'(bus_if.mem_write), 32'd1);
            check_eq("st_mem_addr", 32'(bus_if.mem_addr), 32'd5);
            if (k == 2) begin
                bus_if.mem_ack = 1'b1;
                #1;
                check_eq("st_no_we", 32'(dst_we), 32'd0);
            end
            tick();
        end
        bus_if.mem_ack = 1'b0;
        check_eq("st_done_mem_req", 32'(bus_if.mem_req), 32'd0);
        check_eq("st_done_fetch", 32'(bus_if.instr_req), 32'd1);

        // LD addr 3: r0 write strobe coincides with mem_ack
        fetch(8'h83);
        tick();
        check_eq("ld_mem_req", 32'(bus_if.mem_req), 32'd1);
        check_eq("ld_mem_write", 32'(bus_if.mem_write), 32'd0);
        check_eq("ld_mem_addr", 32'(bus_if.mem_addr), 32'd3);
        check_eq("ld_we_before_ack", 32'(dst_we), 32'd0);
        bus_if.mem_ack = 1'b1;
        #1;
        check_eq("ld_we_on_ack", 32'(dst_we), 32'h1);
        tick();
        bus_if.mem_ack = 1'b0;
        check_eq("ld_we_after", 32'(dst_we), 32'd0);
        check_eq("ld_mem_req_after", 32'(bus_if.mem_req), 32'd0);

        // MOV r3 <- r7 is illegal with four registers
        fetch(8'h1F);
        tick();
        check_eq("ill_flag", 32'(illegal), 32'd1);
        check_eq("ill_no_we", 32'(dst_we), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        check_eq("ill_trap_halted", 32'(halted), 32'd1);
        check_eq("ill_trap_no_req", 32'(bus_if.instr_req), 32'd0);
`else
        check_eq("ill_nop_halted", 32'(halted), 32'd0);
        check_eq("ill_nop_req", 32'(bus_if.instr_req), 32'd1);
        fetch(8'hC0);
        tick();
        check_eq("ill_sticky", 32'(illegal), 32'd1);
        check_eq("ill_continue_req", 32'(bus_if.instr_req), 32'd1);
`endif
        apply_reset();
        check_eq("ill_cleared", 32'(illegal), 32'd0);

        // PC wrap: 255 NOPs then one more
        for (int i = 0; i < 255; i++) begin
            fetch(8'hC0);
            tick();
        end
        check_eq("wrap_pc_ff", 32'(bus_if.instr_addr), 32'hFF);
        fetch(8'hC0);
        check_eq("wrap_pc_0", 32'(bus_if.instr_addr), 32'd0);
        tick();

        // Reset while a load waits for its acknowledge
        fetch(8'h81);
        tick();
        check_eq("rld_mem_req", 32'(bus_if.mem_req), 32'd1);
        rst            = 1'b1;
        bus_if.mem_ack = 1'b1;
        #1;
        check_eq("rld_mem_req_rst", 32'(bus_if.mem_req), 32'd0);
        check_eq("rld_we_rst", 32'(dst_we), 32'd0);
        check_eq("rld_req_rst", 32'(bus_if.instr_req), 32'd0);
        check_eq("rld_src_rst", 32'(src_sel), 32'd0);
        check_eq("rld_alu_rst", 32'(alu_sel), 32'd0);
        tick();
        run = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rld_we_quiet", 32'(dst_we), 32'd0);
            check_eq("rld_mem_quiet", 32'(bus_if.mem_req), 32'd0);
        end
        bus_if.mem_ack = 1'b0;

        // run gates the request; dropping it withdraws a pending request
        check_eq("run0_no_req", 32'(bus_if.instr_req), 32'd0);
        run = 1'b1;
        tick();
        check_eq("run1_req", 32'(bus_if.instr_req), 32'd1);
        run = 1'b0;
        tick();
        check_eq("run0_withdraw", 32'(bus_if.instr_req), 32'd0);
        run = 1'b1;

        // HLT is terminal
        fetch(8'hFF);
        tick();
        check_eq("hlt_halted", 32'(halted), 32'd1);
        check_eq("hlt_no_req", 32'(bus_if.instr_req), 32'd0);
        bus_if.instr_valid = 1'b1;
        bus_if.instr_data  = 8'h01;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("hlt_stay", 32'(halted), 32'd1);
            check_eq("hlt_req_stay", 32'(bus_if.instr_req), 32'd0);
            check_eq("hlt_we_stay", 32'(dst_we), 32'd0);
            check_eq("hlt_pc_stay", 32'(bus_if.instr_addr), 32'd1);
        end
        bus_if.instr_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
